// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared types and defaults for the NEO sample reader
// Purpose : reader FSM state encoding and default sample width / sweep depth.
// Ports   : none (package).
// Config  : NEO_COMPUTE_EN (see neo_sample_reader.sv).
package neo_pkg;

   localparam int N_DEF = 16;
   localparam int M_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      OUT,
      DONE
   } reader_state_t;

endpackage

// File: rtl/neo_window_shift.sv
// rtl/neo_window_shift.sv - 3-deep signed sample window shift register
// Purpose : holds x[n-1], x[n], x[n+1]; new samples enter at x_next.
// Ports   : i_clk, i_reset (async, active-high), i_clr (sync clear),
//           i_shift (shift enable), i_din (new sample),
//           o_x_prev / o_x_curr / o_x_next (window taps).
module neo_window_shift #(
   parameter int N = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clr,
   input  logic                i_shift,
   input  logic signed [N-1:0] i_din,
   output logic signed [N-1:0] o_x_prev,
   output logic signed [N-1:0] o_x_curr,
   output logic signed [N-1:0] o_x_next
);

   logic signed [N-1:0] r_prev;
   logic signed [N-1:0] r_curr;
   logic signed [N-1:0] r_next;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_prev <= '0;
         r_curr <= '0;
         r_next <= '0;
      end else if (i_clr) begin
         r_prev <= '0;
         r_curr <= '0;
         r_next <= '0;
      end else if (i_shift) begin
         r_prev <= r_curr;
         r_curr <= r_next;
         r_next <= i_din;
      end
   end

   assign o_x_prev = r_prev;
   assign o_x_curr = r_curr;
   assign o_x_next = r_next;

endmodule

// File: rtl/neo_sample_reader.sv
// rtl/neo_sample_reader.sv - sweeps sample memory and emits 3-sample windows
// Purpose : reads addresses 0..M-1 (1-cycle read latency), builds sliding
//           windows (x[n-1], x[n], x[n+1]) and hands them downstream over
//           valid/ready. Optional NEO result psi = x[n]^2 - x[n-1]*x[n+1].
// Config  : NEO_COMPUTE_EN defined -> psi computed; undefined -> psi tied to 0.
// Ports   : i_clk, i_reset (async, active-high), i_start (pulse),
//           o_raddr (registered read address), i_rdata (read data),
//           o_out_valid / i_out_ready (window handshake),
//           o_x_prev / o_x_curr / o_x_next (window), o_psi (NEO result),
//           o_busy (sweep in progress), o_done (1-cycle end-of-sweep pulse).
module neo_sample_reader
   import neo_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int M  = M_DEF,
   parameter int AW = $clog2(M) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   output logic [AW-1:0]         o_raddr,
   input  logic signed [N-1:0]   i_rdata,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic signed [N-1:0]   o_x_prev,
   output logic signed [N-1:0]   o_x_curr,
   output logic signed [N-1:0]   o_x_next,
   output logic signed [2*N:0]   o_psi,
   output logic                  o_busy,
   output logic                  o_done
);

   reader_state_t       r_state;
   logic [AW-1:0]       r_ptr;
   logic [1:0]          r_fill;
   logic [AW-1:0]       r_raddr;
   logic                r_out_valid;
   logic                r_busy;
   logic                r_done;

   logic [AW-1:0]       w_ptr_inc;
   logic [1:0]          w_fill_inc;
   logic                w_shift;
   logic                w_clr;
   logic                w_last;
   logic signed [N-1:0] w_x_curr;
   logic signed [N-1:0] w_x_next;

   assign w_ptr_inc  = r_ptr + 1'b1;
   assign w_fill_inc = (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
   assign w_shift    = (r_state == CAPTURE);
   assign w_clr      = (r_state == IDLE) && i_start;
   // ptr has already advanced past the last captured address
   assign w_last     = (r_ptr == AW'(M));

   neo_window_shift #(.N(N)) u_window (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clr    (w_clr),
      .i_shift  (w_shift),
      .i_din    (i_rdata),
      .o_x_prev (o_x_prev),
      .o_x_curr (w_x_curr),
      .o_x_next (w_x_next)
   );

   assign o_x_curr = w_x_curr;
   assign o_x_next = w_x_next;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_fill      <= '0;
         r_raddr     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_ptr   <= '0;
                  r_fill  <= '0;
                  r_raddr <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               r_ptr  <= w_ptr_inc;
               r_fill <= w_fill_inc;
               // after the final capture the address is held so it never reaches M
               if (w_ptr_inc < AW'(M)) begin
                  r_raddr <= w_ptr_inc;
               end
               if (w_fill_inc == 2'd3) begin
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
               end else begin
                  r_state <= ISSUE;
               end
            end
            OUT: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= ISSUE;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_raddr     = r_raddr;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

`ifdef NEO_COMPUTE_EN
   // Operands are sign-extended to full product width so the multiplies are
   // exact; psi is evaluated on the window that will exist after the shift.
   logic signed [2*N-1:0] w_a;
   logic signed [2*N-1:0] w_b;
   logic signed [2*N-1:0] w_c;
   logic signed [2*N-1:0] w_sq;
   logic signed [2*N-1:0] w_cross;
   logic signed [2*N:0]   w_psi;
   logic signed [2*N:0]   r_psi;

   assign w_a     = {{N{w_x_curr[N-1]}}, w_x_curr};
   assign w_b     = {{N{w_x_next[N-1]}}, w_x_next};
   assign w_c     = {{N{i_rdata[N-1]}},  i_rdata};
   assign w_sq    = w_b * w_b;
   assign w_cross = w_a * w_c;
   assign w_psi   = {w_sq[2*N-1], w_sq} - {w_cross[2*N-1], w_cross};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_psi <= '0;
      end else if ((r_state == CAPTURE) && (w_fill_inc == 2'd3)) begin
         r_psi <= w_psi;
      end
   end

   assign o_psi = r_psi;
`else
   assign o_psi = '0;
`endif

endmodule

// File: tb/tb_neo_sample_reader.sv
// tb/tb_neo_sample_reader.sv - scoreboard bench for neo_sample_reader (M=16 and M=3)
module tb_neo_sample_reader;

   typedef struct {
      longint p;
      longint c;
      longint n;
      longint psi;
   } win_t;

   logic               clk;
   logic               reset;
   logic               start;
   logic [4:0]         raddr;
   logic signed [15:0] rdata;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] x_prev, x_curr, x_next;
   logic signed [32:0] psi;
   logic               busy, done;

   logic               start3;
   logic [2:0]         raddr3;
   logic signed [15:0] rdata3;
   logic               out_valid3;
   logic               out_ready3;
   logic signed [15:0] x_prev3, x_curr3, x_next3;
   logic signed [32:0] psi3;
   logic               busy3, done3;

   logic signed [15:0] mem  [16];
   logic signed [15:0] mem3 [3];

   win_t sb[$];
   win_t sb3[$];
   int   checks   = 0;
   int   errors   = 0;
   int   win_cnt  = 0;
   int   done_cnt = 0;
   int   raddr_max = 0;
   int   win3_cnt = 0;
   int   done3_cnt = 0;
   int   raddr3_max = 0;

   neo_sample_reader #(.N(16), .M(16)) u_dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .o_raddr     (raddr),
      .i_rdata     (rdata),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_x_prev    (x_prev),
      .o_x_curr    (x_curr),
      .o_x_next    (x_next),
      .o_psi       (psi),
      .o_busy      (busy),
      .o_done      (done)
   );

   neo_sample_reader #(.N(16), .M(3)) u_dut3 (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start3),
      .o_raddr     (raddr3),
      .i_rdata     (rdata3),
      .o_out_valid (out_valid3),
      .i_out_ready (out_ready3),
      .o_x_prev    (x_prev3),
      .o_x_curr    (x_curr3),
      .o_x_next    (x_next3),
      .o_psi       (psi3),
      .o_busy      (busy3),
      .o_done      (done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // registered-read memory models
   always @(posedge clk) begin
      rdata  <= (raddr < 5'd16) ? mem[raddr[3:0]] : 16'sh7fff;
      rdata3 <= (raddr3 < 3'd3) ? mem3[raddr3[1:0]] : 16'sh7fff;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint neo_psi(input longint a, input longint b, input longint c);
`ifdef NEO_COMPUTE_EN
      return b * b - a * c;
`else
      return 0;
`endif
   endfunction

   task automatic push_expected();
      for (int n = 0; n < 14; n++) begin
         sb.push_back('{longint'(mem[n]), longint'(mem[n+1]), longint'(mem[n+2]),
                        neo_psi(mem[n], mem[n+1], mem[n+2])});
      end
   endtask

   // output monitors: pop scoreboard on every accepted window
   always @(negedge clk) begin
      if (!reset) begin
         if (int'(raddr) > raddr_max) raddr_max = int'(raddr);
         if (int'(raddr3) > raddr3_max) raddr3_max = int'(raddr3);
         if (done) done_cnt++;
         if (done3) done3_cnt++;
         if (out_valid && out_ready) begin
            win_cnt++;
            if (sb.size() == 0) begin
               check("sb_underflow", 0, 1);
            end else begin
               win_t w;
               w = sb.pop_front();
               check("x_prev", x_prev, w.p);
               check("x_curr", x_curr, w.c);
               check("x_next", x_next, w.n);
               check("psi", psi, w.psi);
            end
         end
         if (out_valid3 && out_ready3) begin
            win3_cnt++;
            if (sb3.size() == 0) begin
               check("sb3_underflow", 0, 1);
            end else begin
               win_t w;
               w = sb3.pop_front();
               check("m3_x_prev", x_prev3, w.p);
               check("m3_x_curr", x_curr3, w.c);
               check("m3_x_next", x_next3, w.n);
               check("m3_psi", psi3, w.psi);
            end
         end
      end
   end

   task automatic clear_counts();
      win_cnt  = 0;
      done_cnt = 0;
      raddr_max = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int t;
      t = 0;
      while (done_cnt == 0 && t < budget) begin
         @(posedge clk); #1;
         t++;
      end
      if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic end_of_run(input string tag);
      check({tag, "_windows"}, win_cnt, 14);
      check({tag, "_dones"}, done_cnt, 1);
      check({tag, "_sb_left"}, sb.size(), 0);
      check({tag, "_raddr_max"}, raddr_max, 15);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      int lat;
      int t;
      reset = 1'b1;
      start = 1'b0;
      start3 = 1'b0;
      out_ready = 1'b0;
      out_ready3 = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
      mem3[0] = 16'sd11;
      mem3[1] = -16'sd22;
      mem3[2] = 16'sd33;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_raddr", raddr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_x_prev", x_prev, 0);
      check("rst_x_curr", x_curr, 0);
      check("rst_x_next", x_next, 0);
      check("rst_psi", psi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1 reset = 1'b0;

      // run 1: ramp 1..16, always ready, first-window latency
      clear_counts();
      push_expected();
      out_ready = 1'b1;
      pulse_start();
      check("busy_on_start", busy, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("first_latency", lat, 6);
      wait_done("run1", 200);
      end_of_run("run1");

      // run 2: backpressure on the first window
      clear_counts();
      push_expected();
      out_ready = 1'b0;
      pulse_start();
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("stall_reach_valid", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_x_prev", x_prev, 1);
         check("stall_x_curr", x_curr, 2);
         check("stall_x_next", x_next, 3);
         check("stall_raddr", raddr, 3);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done("run2", 200);
      end_of_run("run2");

      // run 3: reset during the 4th window's ISSUE, then a clean restart
      clear_counts();
      push_expected();
      pulse_start();
      t = 0;
      while (win_cnt < 3 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("rst_mid_windows", win_cnt, 3);
      check("rst_mid_valid_low", out_valid, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_raddr", raddr, 0);
      check("rst_mid_x_prev", x_prev, 0);
      check("rst_mid_x_curr", x_curr, 0);
      check("rst_mid_x_next", x_next, 0);
      check("rst_mid_psi", psi, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      sb.delete();
      @(posedge clk); #1 reset = 1'b0;
      clear_counts();
      push_expected();
      pulse_start();
      wait_done("run3", 200);
      end_of_run("run3");

      // run 4: start while busy and coincident with done is ignored
      clear_counts();
      push_expected();
      pulse_start();
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t = 0;
      while (!done && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("coinc_done_seen", done, 1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      end_of_run("run4");
      check("coinc_no_restart_valid", out_valid, 0);

      // run 5: signed pattern with random backpressure
      mem[0] = 16'sd3;
      mem[1] = 16'sd5;
      mem[2] = 16'sd7;
      mem[3] = -16'sd4;
      mem[4] = 16'sd2;
      mem[5] = 16'sd4;
      for (int i = 6; i < 16; i++) mem[i] = 16'($urandom_range(0, 65535));
      mem[15] = -16'sd32768;
      clear_counts();
      push_expected();
      pulse_start();
      t = 0;
      while (done_cnt == 0 && t < 600) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         t++;
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      if (done_cnt == 0) check("run5_timeout", 0, 1);
      end_of_run("run5");

      // run 6: M=3 instance, single window
      sb3.push_back('{longint'(mem3[0]), longint'(mem3[1]), longint'(mem3[2]),
                      neo_psi(mem3[0], mem3[1], mem3[2])});
      out_ready3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      t = 0;
      while (done3_cnt == 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (10) @(posedge clk);
      #1;
      check("m3_windows", win3_cnt, 1);
      check("m3_dones", done3_cnt, 1);
      check("m3_raddr_max", raddr3_max, 2);
      check("m3_sb_left", sb3.size(), 0);
      check("m3_busy_end", busy3, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
